// File: rtl/layer_seq_pkg.sv
// Shared state encoding and sign-magnitude Q3.12 helpers for the layer sequencer.
package layer_seq_pkg;

   localparam int unsigned WIDTH    = 16;
   localparam int unsigned FRAC     = 12;
   localparam int unsigned SIGN_BIT = 15;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StCapture,
      StFinish,
      StErr
   } seq_state_e;

   // Sign-magnitude: any value with the sign bit set, including -0, clamps to zero.
   function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] x);
      return x[SIGN_BIT] ? '0 : x;
   endfunction

endpackage

// File: rtl/mac_watchdog.sv
// Run-phase watchdog: counts enabled cycles and raises tc once TIMEOUT-1 is reached.
module mac_watchdog #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable && !tc) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign tc = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Sequences the shared MAC engine across one fully-connected layer, one neuron at a time.
// Build option: define LAYER_SEQ_RELU_EN to clamp negative results to zero at capture.
module layer_sequencer
   import layer_seq_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 4,
   parameter int unsigned NUM_INPUTS  = 12,
   parameter int          BASE_ADDR   = 0,
   parameter int unsigned MAC_IDLE    = 2,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   output logic                              mac_run,
   output logic signed [31:0]                mac_start,
   output logic signed [31:0]                mac_size,
   input  logic                              mac_done,
   input  logic [WIDTH-1:0]                  mac_out,
   output logic [NUM_NEURONS-1:0][WIDTH-1:0] neuron_out,
   output logic                              out_valid,
   output logic                              busy,
   output logic                              done,
   output logic                              error
);

   localparam int unsigned NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int unsigned IW = (MAC_IDLE > 1) ? $clog2(MAC_IDLE) : 1;
   localparam logic [NW-1:0] LAST_N    = NW'(NUM_NEURONS - 1);
   localparam logic [IW-1:0] LAST_IDLE = IW'(MAC_IDLE - 1);

   seq_state_e       state_q;
   logic [NW-1:0]    n_q;
   logic [IW-1:0]    idle_cnt_q;
   logic [WIDTH-1:0] cap_val;
   logic             wd_tc;

`ifdef LAYER_SEQ_RELU_EN
   assign cap_val = relu(mac_out);
`else
   assign cap_val = mac_out;
`endif

   assign mac_size = NUM_INPUTS;

   // Held clear outside RUN, so every neuron starts its RUN phase from zero.
   mac_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q != StRun),
      .enable (state_q == StRun),
      .tc     (wd_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         n_q        <= '0;
         idle_cnt_q <= '0;
         mac_run    <= 1'b0;
         mac_start  <= BASE_ADDR;
         neuron_out <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle, StErr: begin
               if (start) begin
                  state_q    <= StLoad;
                  n_q        <= '0;
                  idle_cnt_q <= '0;
                  mac_start  <= BASE_ADDR;
                  out_valid  <= 1'b0;
                  busy       <= 1'b1;
                  error      <= 1'b0;
               end
            end
            StLoad: begin
               if (idle_cnt_q == LAST_IDLE) begin
                  state_q <= StRun;
                  mac_run <= 1'b1;
               end else begin
                  idle_cnt_q <= idle_cnt_q + 1'b1;
               end
            end
            StRun: begin
               // A completion on the terminal-count cycle still counts as success.
               if (mac_done) begin
                  state_q <= StCapture;
                  mac_run <= 1'b0;
               end else if (wd_tc) begin
                  state_q <= StErr;
                  mac_run <= 1'b0;
                  busy    <= 1'b0;
                  error   <= 1'b1;
               end
            end
            StCapture: begin
               neuron_out[n_q] <= cap_val;
               if (n_q == LAST_N) begin
                  state_q <= StFinish;
               end else begin
                  state_q    <= StLoad;
                  n_q        <= n_q + 1'b1;
                  idle_cnt_q <= '0;
                  mac_start  <= mac_start + NUM_INPUTS;
               end
            end
            StFinish: begin
               state_q   <= StIdle;
               done      <= 1'b1;
               out_valid <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               mac_run <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: a mock MAC plus a pass-level reference model.
// Expected capture values follow LAYER_SEQ_RELU_EN when it is defined.
`timescale 1ns/1ps
module tb_layer_sequencer;
   import layer_seq_pkg::*;

   localparam int unsigned NN = 4;
   localparam int unsigned NI = 12;
   localparam int          BA = 0;
   localparam int unsigned MI = 2;
   localparam int unsigned TO = 1024;

   logic              clk = 1'b0;
   logic              reset, start, mac_run, mac_done, out_valid, busy, done, error;
   logic signed [31:0] mac_start, mac_size;
   logic [15:0]       mac_out;
   logic [NN-1:0][15:0] neuron_out;

   always #5 clk = ~clk;

   layer_sequencer #(
      .NUM_NEURONS (NN),
      .NUM_INPUTS  (NI),
      .BASE_ADDR   (BA),
      .MAC_IDLE    (MI),
      .TIMEOUT     (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mac_run    (mac_run),
      .mac_start  (mac_start),
      .mac_size   (mac_size),
      .mac_done   (mac_done),
      .mac_out    (mac_out),
      .neuron_out (neuron_out),
      .out_valid  (out_valid),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Mock MAC configuration: lat[k] = RUN cycles until done (0 = never), val[k] = result.
   int          lat [NN];
   logic [15:0] val [NN];
   bit          spur_en;
   bit          stable_ok;
   int          mk_idx;
   int          runs_started;
   logic signed [31:0] seen_start [$];
   logic [15:0] model_out [NN];

   localparam logic [15:0] NEG_ONE = 16'((1 << SIGN_BIT) | (1 << FRAC));

   function automatic logic [15:0] act(input logic [15:0] v);
`ifdef LAYER_SEQ_RELU_EN
      return (v >= 16'h8000) ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   initial begin
      int run_cnt;
      logic signed [31:0] first_start;
      run_cnt = 0;
      first_start = '0;
      mac_done = 1'b0;
      mac_out = '0;
      forever begin
         @(negedge clk);
         mac_done = 1'b0;
         if (mac_run) begin
            run_cnt++;
            if (run_cnt == 1) begin
               first_start = mac_start;
               seen_start.push_back(mac_start);
               runs_started++;
            end else if (mac_start !== first_start) begin
               stable_ok = 1'b0;
            end
            if (mk_idx < NN && lat[mk_idx] != 0 && run_cnt == lat[mk_idx]) begin
               mac_done = 1'b1;
               mac_out = val[mk_idx];
               mk_idx++;
            end
         end else begin
            run_cnt = 0;
            if (spur_en && $urandom_range(3) == 0) mac_done = 1'b1;
         end
      end
   end

   task automatic run_pass(input bit poke_busy, input string tag);
      int exp_cyc, fail_at, c, done_cyc, err_cyc, n_done, budget, n_runs;
      bit poked;
      exp_cyc = 0;
      fail_at = -1;
      for (int k = 0; k < NN; k++) begin
         if (lat[k] == 0 || lat[k] > TO) begin
            fail_at = k;
            exp_cyc += MI + TO + 1;
            break;
         end
         exp_cyc += MI + lat[k] + 1;
      end
      if (fail_at < 0) exp_cyc += 2;
      mk_idx = 0;
      runs_started = 0;
      stable_ok = 1'b1;
      seen_start.delete();

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      done_cyc = -1;
      err_cyc = -1;
      n_done = 0;
      poked = 1'b0;
      budget = exp_cyc + 20;
      while (c <= budget) begin
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (error && err_cyc < 0) err_cyc = c;
         if (poke_busy && !poked && mac_run && runs_started == 3) begin
            start = 1'b1;
            poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         c++;
      end
      start = 1'b0;

      n_runs = (fail_at < 0) ? NN : fail_at + 1;
      for (int k = 0; k < n_runs && k < NN; k++) begin
         if (fail_at < 0 || k < fail_at) model_out[k] = act(val[k]);
      end
      if (fail_at < 0) begin
         check({tag, " done_cycle"}, done_cyc, exp_cyc);
         check({tag, " done_count"}, n_done, 1);
         check({tag, " out_valid"}, out_valid, 1'b1);
         check({tag, " error"}, error, 1'b0);
      end else begin
         check({tag, " error_cycle"}, err_cyc, exp_cyc);
         check({tag, " done_count"}, n_done, 0);
         check({tag, " error"}, error, 1'b1);
         check({tag, " mac_run"}, mac_run, 1'b0);
         check({tag, " out_valid"}, out_valid, 1'b0);
      end
      check({tag, " busy"}, busy, 1'b0);
      check({tag, " mac_start_stable"}, stable_ok, 1'b1);
      check({tag, " run_count"}, seen_start.size(), n_runs);
      for (int k = 0; k < NN; k++) begin
         check($sformatf("%s neuron_out[%0d]", tag, k), neuron_out[k], model_out[k]);
         if (k < seen_start.size())
            check($sformatf("%s mac_start[%0d]", tag, k), seen_start[k], BA + k * NI);
      end
   endtask

   task automatic rand_cfg(input int lo, input int hi);
      for (int k = 0; k < NN; k++) begin
         lat[k] = $urandom_range(hi, lo);
         val[k] = 16'($urandom);
      end
   endtask

   initial begin
      int w;
      reset = 1'b1;
      start = 1'b0;
      spur_en = 1'b0;
      stable_ok = 1'b1;
      mk_idx = 0;
      runs_started = 0;
      for (int k = 0; k < NN; k++) begin
         lat[k] = 1;
         val[k] = '0;
         model_out[k] = '0;
      end
      repeat (3) @(negedge clk);
      check("rst mac_run", mac_run, 1'b0);
      check("rst mac_start", mac_start, BA);
      check("rst mac_size", mac_size, NI);
      check("rst neuron_out", neuron_out, '0);
      check("rst out_valid", out_valid, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst error", error, 1'b0);
      reset = 1'b0;

      // Nominal layer: T=48 everywhere, so done lands 206 cycles after start.
      for (int k = 0; k < NN; k++) lat[k] = 48;
      val[0] = 16'h1000; val[1] = 16'h2000; val[2] = 16'h0800; val[3] = 16'h3000;
      run_pass(1'b0, "nominal");

      // Negative values, including -1.0 and negative zero.
      rand_cfg(1, 30);
      val[0] = 16'($urandom_range(16'h7fff));
      val[1] = NEG_ONE;
      val[2] = 16'h8000;
      run_pass(1'b0, "relu");

      // Random passes with stray mac_done pulses outside RUN.
      spur_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_cfg(1, 40);
         run_pass(1'b0, $sformatf("rand%0d", i));
      end

      rand_cfg(10, 40);
      run_pass(1'b1, "start_busy");
      spur_en = 1'b0;

      // Neuron 1 never completes; then a fresh start recovers from ERR.
      rand_cfg(5, 20);
      lat[1] = 0;
      run_pass(1'b0, "timeout");
      rand_cfg(1, 30);
      run_pass(1'b0, "recover");

      // Completion on exactly the terminal-count cycle.
      rand_cfg(1, 10);
      lat[2] = TO;
      run_pass(1'b0, "tc_edge");

      // Reset during neuron 1 RUN.
      rand_cfg(30, 30);
      mk_idx = 0;
      runs_started = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!(mac_run && runs_started == 2) && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("rstmid reached_run", (w < 500), 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid mac_run", mac_run, 1'b0);
      check("rstmid busy", busy, 1'b0);
      check("rstmid out_valid", out_valid, 1'b0);
      check("rstmid neuron_out", neuron_out, '0);
      check("rstmid mac_start", mac_start, BA);
      reset = 1'b0;
      for (int k = 0; k < NN; k++) model_out[k] = '0;
      rand_cfg(1, 25);
      run_pass(1'b0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

- Sequences the shared multiply-accumulate neuron engine across one fully-connected layer.
- For each neuron n it configures the MAC's weight window (start address and size), runs it, waits for completion and captures the Q3.12 result into an output register array.
- Sits between the network top-level control and the MAC, so a whole layer is computed by one start pulse.
- An optional ReLU is applied at capture time.

## Interface
Parameters:
- NUM_NEURONS, 4, neurons in the layer (≥1)
- NUM_INPUTS, 12, inputs per neuron; per-neuron weight stride
- BASE_ADDR, 0, weight-memory address of neuron 0's first weight
- MAC_IDLE, 2, cycles mac_run held low before each neuron (≥2)
- TIMEOUT, 1024, max RUN cycles waiting for mac_done

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a layer pass; sampled only in IDLE or ERR
- mac_run  out  1  MAC enable
- mac_start  out  32 signed  first weight address for the current neuron
- mac_size  out  32 signed  constant NUM_INPUTS
- mac_done  in  1  MAC finished current neuron
- mac_out  in  16  MAC accumulated result, sign-magnitude Q3.12
- neuron_out  out  16 × NUM_NEURONS  captured results, index = neuron
- out_valid  out  1  neuron_out holds a complete pass
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- error  out  1  sticky MAC timeout flag

## Operation
- States:
  - IDLE: start=1 → LOAD with n=0, mac_start=BASE_ADDR, out_valid←0.
  - LOAD: mac_run=0 for MAC_IDLE cycles (this reloads the MAC and clears its accumulator), then → RUN.
  - RUN: mac_run=1, waits for mac_done=1 → CAPTURE.
    - If the watchdog reaches TIMEOUT first → ERR.
  - CAPTURE: neuron_out[n]←act(mac_out); mac_run=0.
    - If n==NUM_NEURONS-1 → FINISH.
    - Otherwise n←n+1, mac_start←mac_start+NUM_INPUTS (running adder, no multiplier) and → LOAD.
  - FINISH: done=1 and out_valid←1 → IDLE.
  - ERR: error=1, mac_run=0, busy=0. start=1 clears error and begins a fresh pass exactly as from IDLE.
- busy=1 in LOAD, RUN, CAPTURE and FINISH.
- act(x) is x unless ReLU is enabled (see Configuration).
- Boundary behaviour:
  - start while busy is ignored.
  - mac_done outside RUN is ignored.
  - mac_done in the same cycle the watchdog hits TIMEOUT: done wins, go to CAPTURE.
  - NUM_NEURONS=1: a single LOAD/RUN/CAPTURE sequence, then FINISH.
  - neuron_out entries not yet overwritten keep their previous values.

## Timing
- Reset values: state IDLE, mac_run 0, mac_start BASE_ADDR, mac_size NUM_INPUTS, neuron_out all 0, out_valid 0, busy 0, done 0, error 0, n 0.
- Reset mid-pass returns to IDLE next cycle; partial results are cleared.
- Let T = cycles with mac_run=1 up to and including the cycle mac_done=1 is sampled.
- Per-neuron cost = MAC_IDLE + T + 1.
- done pulses NUM_NEURONS·(MAC_IDLE+T+1)+2 cycles after the edge that samples start.
- neuron_out[n] is valid the cycle after CAPTURE.
- mac_start changes only in IDLE→LOAD and CAPTURE, so it is stable for the entire RUN.
- Watchdog:
  - Cleared on LOAD→RUN and counts every RUN cycle.
  - ERR is entered on the edge where the count equals TIMEOUT-1 and mac_done=0.

## Configuration
- LAYER_SEQ_RELU_EN defined: at capture, if mac_out[15]=1 (negative), store 16'h0000; otherwise store mac_out. Negative zero (16'h8000) is stored as 0.
- Not defined: mac_out is stored unmodified.

## Structure
- Package layer_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, CAPTURE, FINISH, ERR)
  - Q-format constants: WIDTH=16, FRAC=12, SIGN_BIT=15
  - relu function on sign-magnitude Q3.12
- One sub-module is natural: mac_watchdog, with clear, enable, terminal-count output and parameter TIMEOUT.
- The FSM, neuron counter, address adder and output registers stay in layer_sequencer.

## Test plan
- **Nominal pass.** Defaults; mock MAC returns done after T=48 with mac_out=0x1000,0x2000,0x0800,0x3000.
  - mac_start sequence is 0,12,24,36.
  - done occurs 206 cycles after start.
  - neuron_out equals those values; out_valid=1.
- **ReLU.** LAYER_SEQ_RELU_EN defined; mac_out=0x9000 (−1.0) for neuron 1 → neuron_out[1]=0x0000, others unchanged. Without the macro → 0x9000.
- **Timeout.** TIMEOUT=16; mock never asserts mac_done.
  - error=1 after 16 RUN cycles, mac_run=0, busy=0, no done pulse.
  - A following start clears error and completes normally.
- **Start while busy.** Second start pulse during RUN of neuron 2 → ignored; a single done pulse; mac_start sequence unchanged.
- **Reset mid-pass.** reset during neuron 1 RUN → next cycle IDLE, mac_run=0, neuron_out all 0, out_valid=0.
- **Done at timeout edge.** mac_done coincides with terminal count → CAPTURE taken, error stays 0.
